alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Multi-cycle execution ALU; consumer of the 4-bit ALUctrl code from the ALU controller.
//  Accepts operands plus code over a valid/ready handshake and computes the result.
//  Returns result, zero, carry, overflow and illegal-code flags over a second handshake.
//  Shifts are iterative (1 bit/cycle). Sits between register-read and writeback/branch logic.
// PARAMETERS
//  WIDTH      32  operand/result width (>=17; LUI uses lower 16 bits of b)
//  SHAMT_W    5   shift-amount bits taken from b[SHAMT_W-1:0]
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operation request
//  in_ready   out  1      unit can accept request (high only in IDLE)
//  alu_ctrl   in   4      operation code, table below
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B / immediate / shift amount
//  out_valid  out  1      result held valid
//  out_ready  in   1      downstream takes result
//  result     out  WIDTH  result
//  zero       out  1      result == 0
//  carry      out  1      carry-out (ADD) / borrow (SUB); 0 for other ops
//  ovf        out  1      signed overflow (ADD/SUB); 0 for other ops
//  illegal    out  1      alu_ctrl was 15 (undefined)
// BEHAVIOUR
//  Codes: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 OR, 5 NOR, 6 SLL, 7 SRL, 8 NE, 9 EQ, 10 SLT,
//   11 LE, 12 GT, 13 GE, 14 LUI (b[15:0]<<16), 15 illegal -> result 0, illegal=1.
//  Compares (8-13) are signed; result is 1 or 0 zero-extended. SRL is logical.
//  FSM states:
//   IDLE  - in_ready=1; on in_valid, latch a/b/code. Shift with nonzero shamt -> SHIFT; else -> DONE.
//   SHIFT - shift accumulator 1 bit/cycle, decrement count; count reaches 0 -> DONE.
//   DONE  - out_valid=1; outputs stable; out_ready -> IDLE.
//  Latency (accept edge -> out_valid): 1 cycle for non-shift ops and zero shamt; 1+shamt for shifts.
//  Throughput: one op per 2 cycles minimum (no accept while DONE).
//  Backpressure: result/flags held indefinitely in DONE while out_ready=0.
//  Inputs ignored outside IDLE; a/b/code changes after accept have no effect.
//  Arithmetic: ADD/SUB computed WIDTH+1 bits; carry = bit WIDTH; ovf from sign bits.
//   SUB carry = 1 when unsigned a < b (borrow).
//  Reset: state=IDLE, in_ready=1 after reset; out_valid, result, zero, carry, ovf, illegal = 0.
//   Reset mid-SHIFT or mid-DONE discards the operation; no output is produced.
// CONFIGURATION
//  ALU_BARREL_SHIFT_EN defined: SLL/SRL complete in one cycle like other ops; no SHIFT state.
//  Undefined (default): iterative shifter as above; smaller area.
//  Results are identical in both builds; only latency differs.
// STRUCTURE
//  Shared package: ALUctrl code localparams (ALU_ADD..ALU_ILLEGAL), WIDTH default,
//   FSM state encodings. The ALU controller uses the same code constants.
//  One sub-module: alu_shift_seq (iterative shifter, start/done, count register);
//   bypassed when ALU_BARREL_SHIFT_EN is defined.
// TESTING
//  ADD a=32'h7FFFFFFF b=1, out_ready=1 -> result 32'h80000000, ovf=1, carry=0, out_valid 1 cycle after accept.
//  SUB a=5 b=5 -> result 0, zero=1, carry=0; SUB a=3 b=5 -> 32'hFFFFFFFE, carry=1.
//  SLL a=1 b=31 -> result 32'h80000000, out_valid 32 cycles after accept (1 with macro).
//  SLT a=32'hFFFFFFFF b=1 -> result 1; GE same operands -> 0; LUI b=16'h1234 -> 32'h12340000.
//  Hold out_ready=0 for 10 cycles after an op -> result/flags stable, in_ready=0, new in_valid ignored.
//  Assert rst during SRL shamt=20 at cycle 5 -> next cycle IDLE, out_valid=0; code 15 -> illegal=1, result 0.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execution ALU and the ALU controller: operation codes,
// default widths and the execution FSM state encoding.
package alu_exec_unit_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_XOR     = 4'd3;
  localparam logic [3:0] ALU_OR      = 4'd4;
  localparam logic [3:0] ALU_NOR     = 4'd5;
  localparam logic [3:0] ALU_SLL     = 4'd6;
  localparam logic [3:0] ALU_SRL     = 4'd7;
  localparam logic [3:0] ALU_NE      = 4'd8;
  localparam logic [3:0] ALU_EQ      = 4'd9;
  localparam logic [3:0] ALU_SLT     = 4'd10;
  localparam logic [3:0] ALU_LE      = 4'd11;
  localparam logic [3:0] ALU_GT      = 4'd12;
  localparam logic [3:0] ALU_GE      = 4'd13;
  localparam logic [3:0] ALU_LUI     = 4'd14;
  localparam logic [3:0] ALU_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative 1-bit-per-cycle shifter: loads on start, then shifts until its count
// runs out; 'last' flags the cycle whose shift produces the final value.
module alu_shift_seq
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               left,
  input  logic [WIDTH-1:0]   value,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               last,
  output logic [WIDTH-1:0]   shifted
);

  logic [WIDTH-1:0]   acc_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic               left_r;

  // accumulator and remaining-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= {WIDTH{1'b0}};
      cnt_r  <= {SHAMT_W{1'b0}};
      left_r <= 1'b0;
    end else if (start) begin
      acc_r  <= value;
      cnt_r  <= shamt;
      left_r <= left;
    end else if (cnt_r != {SHAMT_W{1'b0}}) begin
      acc_r <= shifted;
      cnt_r <= cnt_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  // one-step shift of the accumulator and final-step detect
  always_comb begin
    if (left_r) begin
      shifted = {acc_r[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, acc_r[WIDTH-1:1]};
    end
    last = (cnt_r == {{(SHAMT_W-1){1'b0}}, 1'b1});
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execution ALU with valid/ready handshakes on both sides.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; default build shifts iteratively.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);

  alu_state_t         state_r, state_nxt_s;
  logic [WIDTH-1:0]   result_r;
  logic               zero_r, carry_r, ovf_r, illegal_r;

  logic [WIDTH:0]     sum_s, diff_s;
  logic [WIDTH+15:0]  lui_wide_s;
  logic [WIDTH-1:0]   op_res_s;
  logic               op_carry_s, op_ovf_s, op_ill_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic               go_shift_s;
  logic               shift_last_s;
  logic [WIDTH-1:0]   shift_val_s;

  assign shamt_s = b[SHAMT_W-1:0];

`ifdef ALU_BARREL_SHIFT_EN
  assign go_shift_s   = 1'b0;
  assign shift_last_s = 1'b0;
  assign shift_val_s  = {WIDTH{1'b0}};
`else
  assign go_shift_s = (state_r == ST_IDLE) && in_valid && is_shift(alu_ctrl)
                      && (shamt_s != {SHAMT_W{1'b0}});

  alu_shift_seq #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start   (go_shift_s),
    .left    (alu_ctrl == ALU_SLL),
    .value   (a),
    .shamt   (shamt_s),
    .last    (shift_last_s),
    .shifted (shift_val_s)
  );
`endif

  // single-cycle operation result and flags from the live request inputs
  always_comb begin
    sum_s      = {1'b0, a} + {1'b0, b};
    diff_s     = {1'b0, a} - {1'b0, b};
    lui_wide_s = {{WIDTH{1'b0}}, b[15:0]} << 5'd16;
    op_res_s   = {WIDTH{1'b0}};
    op_carry_s = 1'b0;
    op_ovf_s   = 1'b0;
    op_ill_s   = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        op_res_s   = sum_s[WIDTH-1:0];
        op_carry_s = sum_s[WIDTH];
        op_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        op_res_s   = diff_s[WIDTH-1:0];
        op_carry_s = diff_s[WIDTH];
        op_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: op_res_s = a & b;
      ALU_XOR: op_res_s = a ^ b;
      ALU_OR:  op_res_s = a | b;
      ALU_NOR: op_res_s = ~(a | b);
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL: op_res_s = a << shamt_s;
      ALU_SRL: op_res_s = a >> shamt_s;
`else
      // only reached with a zero shift amount; nonzero amounts go to the shifter
      ALU_SLL: op_res_s = a;
      ALU_SRL: op_res_s = a;
`endif
      ALU_NE:  op_res_s = {{(WIDTH-1){1'b0}}, (a != b)};
      ALU_EQ:  op_res_s = {{(WIDTH-1){1'b0}}, (a == b)};
      ALU_SLT: op_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
      ALU_LE:  op_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
      ALU_GT:  op_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) >  $signed(b))};
      ALU_GE:  op_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
      ALU_LUI: op_res_s = lui_wide_s[WIDTH-1:0];
      default: op_ill_s = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (go_shift_s) begin
            state_nxt_s = ST_SHIFT;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (shift_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // result/flag registers: load on accept or shift completion, hold while DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r  <= {WIDTH{1'b0}};
      zero_r    <= 1'b0;
      carry_r   <= 1'b0;
      ovf_r     <= 1'b0;
      illegal_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && in_valid && !go_shift_s) begin
      result_r  <= op_res_s;
      zero_r    <= (op_res_s == {WIDTH{1'b0}});
      carry_r   <= op_carry_s;
      ovf_r     <= op_ovf_s;
      illegal_r <= op_ill_s;
    end else if ((state_r == ST_SHIFT) && shift_last_s) begin
      result_r  <= shift_val_s;
      zero_r    <= (shift_val_s == {WIDTH{1'b0}});
      carry_r   <= 1'b0;
      ovf_r     <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      result_r  <= result_r;
      zero_r    <= zero_r;
      carry_r   <= carry_r;
      ovf_r     <= ovf_r;
      illegal_r <= illegal_r;
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign result    = result_r;
  assign zero      = zero_r;
  assign carry     = carry_r;
  assign ovf       = ovf_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit plus backpressure and mid-operation reset sequences.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        ovf;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [3:0]  code;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic int lat_sh(input int sh);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    return (sh == 0) ? 1 : 1 + sh;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [3:0] code, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] res, input logic z,
                     input logic c, input logic o, input logic il, input int lat);
    vec_t v;
    v.name = name; v.code = code; v.av = av; v.bv = bv; v.res = res;
    v.z = z; v.c = c; v.o = o; v.il = il; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen (or the bound expires).
  task automatic issue(input logic [3:0] code, input logic [31:0] av, input logic [31:0] bv,
                       output int lat);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; alu_ctrl = code; a = av; b = bv;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; alu_ctrl = 4'd15; a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); @(negedge clk); lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_ctrl = 4'd0; a = 32'd0; b = 32'd0;

    add("add_ovf",   4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    add("add_wrap",  4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    add("add_negov", 4'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    add("sub_eq",    4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add("sub_brw",   4'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    add("sub_ovf",   4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    add("and",       4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("xor",       4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("or",        4'd4,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("nor",       4'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("sll31",     4'd6,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, lat_sh(31));
    add("sll4",      4'd6,  32'h00000003, 32'h00000004, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0, lat_sh(4));
    add("srl20",     4'd7,  32'h80000000, 32'h00000014, 32'h00000800, 1'b0, 1'b0, 1'b0, 1'b0, lat_sh(20));
    add("srl0",      4'd7,  32'h12345678, 32'hFFFFFFE0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, lat_sh(0));
    add("ne",        4'd8,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add("eq",        4'd9,  32'h00000005, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("slt",       4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("le_eq",     4'd11, 32'h00000001, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("le_gt",     4'd11, 32'h00000002, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add("gt",        4'd12, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("ge",        4'd13, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add("lui",       4'd14, 32'h0000FFFF, 32'hABCD1234, 32'h12340000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("illegal",   4'd15, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_flags",     {28'b0, zero, carry, ovf, illegal}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].code, vecs[i].av, vecs[i].bv, lat);
      chk({vecs[i].name, "_lat"},    lat, vecs[i].lat);
      chk({vecs[i].name, "_result"}, result, vecs[i].res);
      chk({vecs[i].name, "_flags"},  {28'b0, zero, carry, ovf, illegal},
          {28'b0, vecs[i].z, vecs[i].c, vecs[i].o, vecs[i].il});
      pop();
      chk({vecs[i].name, "_popped"}, {31'b0, out_valid}, 32'd0);
    end

    // backpressure: result held for 10 cycles while a new request is offered and ignored
    issue(4'd0, 32'h7FFFFFFF, 32'h00000001, lat);
    chk("bp_lat", lat, 32'd1);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; alu_ctrl = 4'd1; a = 32'd1; b = 32'd2;
      @(posedge clk); @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
      chk("bp_result",    result, 32'h80000000);
      chk("bp_flags",     {28'b0, zero, carry, ovf, illegal}, 32'h2);
    end
    in_valid = 1'b0;
    pop();
    chk("bp_after_pop_ready", {31'b0, in_ready},  32'd1);
    @(posedge clk); @(negedge clk);
    chk("bp_no_ghost_op",     {31'b0, out_valid}, 32'd0);

    // reset in the fifth cycle of an SRL by 20
    in_valid = 1'b1; alu_ctrl = 4'd7; a = 32'hFFFFFFFF; b = 32'd20;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result",    result, 32'd0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_output", seen, 32'd0);

    issue(4'd1, 32'h00000003, 32'h00000005, lat);
    chk("post_rst_lat",    lat, 32'd1);
    chk("post_rst_result", result, 32'hFFFFFFFE);
    chk("post_rst_carry",  {31'b0, carry}, 32'd1);
    pop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
